// File: rtl/arb_pkg.sv
// Shared types for the round-robin channel arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/decoder2to4.sv
// Library 2-to-4 one-hot decoder with active-high enable s.
module decoder2to4 (
  input  logic [1:0] a,
  input  logic       s,
  output logic [3:0] y
);

  // Output is all zero when disabled, otherwise one-hot on a.
  always_comb begin
    y = 4'b0000;
    if (s) y[a] = 1'b1;
  end

endmodule

// File: rtl/mux4to1.sv
// Library 4-to-1 bit multiplexer with active-high enable e.
module mux4to1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  input  logic       e,
  output logic       y
);

  // Selected bit, forced low when disabled.
  always_comb begin
    y = e & d[s];
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request bit searching ptr+1, ptr+2,
// ptr+3, ptr (mod 4). Purely combinational.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   ptr,
  output logic       valid,
  output req_idx_t   idx
);

  req_idx_t cand;

  // Walk the four positions after ptr; the last one visited is ptr itself.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + req_idx_t'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter sharing one serial data bit between four requesters,
// with bounded hold time and one idle turnaround cycle between owners.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no owner; arbitrate on every edge
//  OWN   | sel_q owns the channel; counting consecutive owned cycles
//  TURN  | single idle cycle after a release; arbitrate on next edge
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       dout,
  output logic       timeout
);

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);

  arb_state_t    state_q, state_d;
  req_idx_t      ptr_q, ptr_d;
  req_idx_t      sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic          pick_valid;
  req_idx_t      pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State, pointer, owner, hold counter and timeout pulse registers.
  // ptr resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; a release in OWN wins over any other request activity,
  // and ptr keeps the previous owner through TURN so it is re-picked last.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE, TURN: begin
        if (pick_valid) begin
          state_d = OWN;
          sel_d   = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = HOLD_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!req[sel_q]) begin
          state_d = TURN;
        end else if (cnt_q == HOLD_MAX) begin
          state_d   = TURN;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + HOLD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == OWN);
  assign sel     = sel_q;
  assign timeout = timeout_q;

  decoder2to4 u_grant_dec (
    .a (sel_q),
    .s (busy),
    .y (grant)
  );

  mux4to1 u_dout_mux (
    .d (din),
    .s (sel_q),
    .e (busy),
    .y (dout)
  );

endmodule
